// File: rtl/nn_mem_pkg.sv
// Shared widths and loader state encoding for the conv input/output memory host interface.
package nn_mem_pkg;

  localparam int DIM_ADDR_W = 9;
  localparam int DIM_DATA_W = 16;
  localparam int DOM_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    GO,
    RUN
  } loader_state_t;

endpackage

// File: rtl/ldr_watchdog.sv
// Run-phase watchdog for the input RAM loader.
// It counts enabled cycles from a clear, and flags the cycle on which the count reaches TIMEOUT_CYCLES-1.
module ldr_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // The loader leaves RUN on expiry, so the counter never wraps while it matters.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/input_ram_loader.sv
// Host-side writer for the conv input RAM: takes one frame from a valid/ready stream, hands the RAM
// to the conv top with a go pulse, then waits for finish under a watchdog and reports done.
module input_ram_loader
  import nn_mem_pkg::*;
#(
  parameter int ADDR_W         = DIM_ADDR_W,
  parameter int DATA_W         = DIM_DATA_W,
  parameter int WORD_COUNT     = 256,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ldr__dim__address,
  output logic              ldr__dim__enable,
  output logic              ldr__dim__write,
  output logic [DATA_W-1:0] ldr__dim__data,
  output logic              dim_owner,
  output logic              ldr__dut__go,
  input  logic              dut__ldr__finish,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int IDX_W = $clog2(WORD_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  if (WORD_COUNT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_count
    $error("input_ram_loader: WORD_COUNT and TIMEOUT_CYCLES must be >= 1");
  end
  if (BASE_ADDR < 0 || BASE_ADDR + WORD_COUNT > (2 ** ADDR_W)) begin : g_bad_range
    $error("input_ram_loader: BASE_ADDR+WORD_COUNT exceeds the input RAM address space");
  end

  loader_state_t    state, next_state;
  logic [IDX_W-1:0] idx;
  logic             handshake;
  logic             expired;

  ldr_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == GO),
    .enable (state == RUN),
    .expired(expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && idx == LAST_IDX) next_state = DRAIN;
      end
      DRAIN: next_state = GO;
      GO:    next_state = RUN;
      RUN:   if (dut__ldr__finish || expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign handshake = s_valid && s_ready;

  // Registered outputs are decoded from next_state so owner and go line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx               <= '0;
      ldr__dim__address <= '0;
      ldr__dim__enable  <= 1'b0;
      ldr__dim__write   <= 1'b0;
      ldr__dim__data    <= '0;
      dim_owner         <= 1'b0;
      ldr__dut__go      <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      ldr__dim__enable <= handshake;
      ldr__dim__write  <= handshake;
      if (handshake) begin
        ldr__dim__address <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        ldr__dim__data    <= s_data;
        idx               <= idx + IDX_W'(1);
      end
      if (state == IDLE && start) begin
        idx     <= '0;
        timeout <= 1'b0;
      end
      dim_owner    <= (next_state == LOAD) || (next_state == DRAIN);
      ldr__dut__go <= (next_state == GO);
      done         <= (state == RUN) && (dut__ldr__finish || expired);
      // Finish wins over a coincident expiry.
      if (state == RUN && expired && !dut__ldr__finish) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_ram_loader.sv
// Self-checking bench for input_ram_loader: two instances (long and short watchdog) driven by directed
// steps with randomized stream data and valid gaps, checked against expectations built from frame rules.
module tb_input_ram_loader;

  localparam int WC   = 4;
  localparam int BASE = 'h010;
  localparam int TO_A = 64;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   [2];
  logic        start   [2];
  logic        s_valid [2];
  logic [15:0] s_data  [2];
  logic        finish  [2];
  logic        s_ready [2];
  logic [8:0]  address [2];
  logic        enable  [2];
  logic        write   [2];
  logic [15:0] data    [2];
  logic        owner   [2];
  logic        go      [2];
  logic        busy    [2];
  logic        done    [2];
  logic        timeout [2];

  int total = 0;
  int bad   = 0;

  input_ram_loader #(
    .ADDR_W(9), .DATA_W(16), .WORD_COUNT(WC), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO_A)
  ) dut_a (
    .clk              (clk),
    .reset            (reset[0]),
    .start            (start[0]),
    .s_valid          (s_valid[0]),
    .s_data           (s_data[0]),
    .s_ready          (s_ready[0]),
    .ldr__dim__address(address[0]),
    .ldr__dim__enable (enable[0]),
    .ldr__dim__write  (write[0]),
    .ldr__dim__data   (data[0]),
    .dim_owner        (owner[0]),
    .ldr__dut__go     (go[0]),
    .dut__ldr__finish (finish[0]),
    .busy             (busy[0]),
    .done             (done[0]),
    .timeout          (timeout[0])
  );

  input_ram_loader #(
    .ADDR_W(9), .DATA_W(16), .WORD_COUNT(WC), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO_B)
  ) dut_b (
    .clk              (clk),
    .reset            (reset[1]),
    .start            (start[1]),
    .s_valid          (s_valid[1]),
    .s_data           (s_data[1]),
    .s_ready          (s_ready[1]),
    .ldr__dim__address(address[1]),
    .ldr__dim__enable (enable[1]),
    .ldr__dim__write  (write[1]),
    .ldr__dim__data   (data[1]),
    .dim_owner        (owner[1]),
    .ldr__dut__go     (go[1]),
    .dut__ldr__finish (finish[1]),
    .busy             (busy[1]),
    .done             (done[1]),
    .timeout          (timeout[1])
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int d);
    check("idle_before_start", busy[d], 0);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check("load_ready", s_ready[d], 1);
    check("load_busy", busy[d], 1);
    check("load_owner", owner[d], 1);
    check("start_clears_timeout", timeout[d], 0);
    check("load_no_done", done[d], 0);
  endtask

  // mode 0: back-to-back 0xA001.. ; mode 1: valid pattern 1,0,0,1,1,0,1 ; mode 2: random gaps and data.
  task automatic run_load(input int d, input int mode, input bit noise);
    logic [6:0]  pat;
    logic [15:0] word;
    logic        hs;
    int          acc;
    pat = 7'b1011001;
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < WC; cyc++) begin
      case (mode)
        0:       s_valid[d] = 1'b1;
        1:       s_valid[d] = (cyc < 7) ? pat[cyc] : 1'b1;
        default: s_valid[d] = 1'($urandom_range(0, 1));
      endcase
      s_data[d] = (mode == 0) ? 16'hA001 + 16'(acc) : 16'($urandom);
      if (noise) start[d] = 1'($urandom_range(0, 1));
      check("load_ready_held", s_ready[d], 1);
      check("load_owner_held", owner[d], 1);
      hs   = s_valid[d] && s_ready[d];
      word = s_data[d];
      tick();
      check("wr_enable", enable[d], hs);
      check("wr_strobe", write[d], hs);
      if (hs) begin
        check("wr_address", address[d], BASE + acc);
        check("wr_data", data[d], word);
        acc++;
      end
    end
    if (acc < WC) check("load_budget_words", acc, WC);
    s_valid[d] = 1'b0;
    start[d]   = 1'b0;
  endtask

  // Enters with the DUT in DRAIN; leaves it on the first RUN cycle.
  task automatic drain_go(input int d, input bit noise);
    check("drain_ready", s_ready[d], 0);
    check("drain_owner", owner[d], 1);
    check("drain_no_go", go[d], 0);
    s_valid[d] = 1'b1;
    s_data[d]  = 16'($urandom);
    start[d]   = noise;
    tick();
    s_valid[d] = 1'b0;
    start[d]   = 1'b0;
    check("go_pulse", go[d], 1);
    check("go_owner_released", owner[d], 0);
    check("go_no_write", enable[d], 0);
    check("go_no_strobe", write[d], 0);
    finish[d] = noise;
    tick();
    finish[d] = 1'b0;
    check("go_one_cycle", go[d], 0);
    check("run_busy", busy[d], 1);
    check("go_finish_ignored", done[d], 0);
  endtask

  // Enters on RUN cycle 1; finish is raised on RUN cycle fin_at (0 = never).
  task automatic run_wait(input int d, input int fin_at, input bit noise);
    int  to;
    bit  ended;
    bit  exp_to;
    to    = (d == 0) ? TO_A : TO_B;
    ended = 1'b0;
    for (int cyc = 1; cyc <= to + 2 && !ended; cyc++) begin
      finish[d] = (cyc == fin_at);
      if (noise) start[d] = 1'($urandom_range(0, 1));
      ended  = finish[d] || (cyc == to);
      exp_to = !finish[d] && (cyc == to);
      tick();
      finish[d] = 1'b0;
      start[d]  = 1'b0;
      check("run_done", done[d], ended);
      check("run_busy_state", busy[d], !ended);
      check("run_no_go", go[d], 0);
      if (ended) check("run_timeout_flag", timeout[d], exp_to);
    end
    tick();
    check("done_one_cycle", done[d], 0);
    check("idle_after_frame", busy[d], 0);
  endtask

  task automatic full_frame(input int d, input int mode, input bit noise, input int fin_at);
    start_frame(d);
    run_load(d, mode, noise);
    drain_go(d, noise);
    run_wait(d, fin_at, noise);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; start[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = '0; finish[d] = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_state_busy", busy[d], 0);
      check("rst_ready", s_ready[d], 0);
      check("rst_enable", enable[d], 0);
      check("rst_write", write[d], 0);
      check("rst_address", address[d], 0);
      check("rst_data", data[d], 0);
      check("rst_owner", owner[d], 0);
      check("rst_go", go[d], 0);
      check("rst_done", done[d], 0);
      check("rst_timeout", timeout[d], 0);
      reset[d] = 1'b0;
    end
    tick();

    // Back-to-back frame, finish 20 cycles after go.
    full_frame(0, 0, 1'b0, 20);
    // Valid gaps 1,0,0,1,1,0,1.
    full_frame(0, 1, 1'b0, 5);

    // Finish while idle must not produce done or start a frame.
    for (int i = 0; i < 3; i++) begin
      finish[0] = 1'b1;
      tick();
      check("idle_finish_no_done", done[0], 0);
      check("idle_finish_no_busy", busy[0], 0);
      check("idle_finish_no_go", go[0], 0);
    end
    finish[0] = 1'b0;
    // Start noise during LOAD/DRAIN/RUN, finish pulsed during GO.
    full_frame(0, 2, 1'b1, 10);

    // Reset after 2 of 4 words, then restart from the base address.
    start_frame(0);
    for (int i = 0; i < 2; i++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 16'($urandom);
      tick();
      check("partial_address", address[0], BASE + i);
      check("partial_enable", enable[0], 1);
    end
    reset[0] = 1'b1;
    tick();
    reset[0]   = 1'b0;
    s_valid[0] = 1'b0;
    check("midrst_enable", enable[0], 0);
    check("midrst_write", write[0], 0);
    check("midrst_go", go[0], 0);
    check("midrst_done", done[0], 0);
    check("midrst_owner", owner[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", s_ready[0], 0);
    full_frame(0, 2, 1'b0, 3);

    // Watchdog expiry on the short-timeout instance; timeout is sticky until the next start.
    full_frame(1, 0, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      check("timeout_sticky", timeout[1], 1);
      tick();
    end
    start[1] = 1'b1;
    check("timeout_until_start", timeout[1], 1);
    start[1] = 1'b0;
    // Finish on the expiry cycle: done without timeout.
    full_frame(1, 2, 1'b0, TO_B);

    // Randomized frames on both instances, finish anywhere including past the watchdog.
    for (int n = 0; n < 4; n++) begin
      full_frame(0, 2, 1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
      full_frame(1, 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
